mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Sequences the CPU's single external RAM port and shares it between instruction fetch (IF) and the mem stage (MEM).
- Converts word, half and byte requests into byte-serial transfers on an 8-bit synchronous RAM and assembles read data.
- Emits one-cycle done pulses so the pipeline can drive its stall logic.
- Sign/zero extension remains in the mem stage; this block returns raw little-endian bytes.

Parameters:
- ADDR_W, 17, width of the external RAM byte address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  IF requests a 4-byte read; held with if_addr until if_done.
- if_addr  in  32  IF byte address.
- if_data  out  32  fetched word; valid in if_done cycle, held until next accept.
- if_done  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  MEM request (the mem stage's ram_valid); held with its other inputs until mem_done.
- mem_write  in  1  1 = store, 0 = load.
- mem_byte  in  4  byte mask: 0001 = 1 byte, 0011 = 2 bytes, 1111 = 4 bytes.
- mem_addr  in  32  MEM byte address.
- mem_wdata  in  32  store data; byte i = mem_wdata[8i+7:8i].
- mem_rdata  out  32  load data; unused upper bytes zero; valid in mem_done cycle, held.
- mem_done  out  1  one-cycle completion pulse for MEM.
- busy  out  1  high whenever state != IDLE.
- ram_a  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write strobe.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data; byte addressed in cycle c appears in cycle c+1.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0 (if_data, mem_rdata, ram_a, ram_din, ram_wr, busy, both done pulses). Reset mid-transfer aborts it, drops ram_wr in the same instant, and discards partial data.
- States: IDLE, XFER, LAST, DONE.
- IDLE: ram_wr=0, ram_a=0, ram_din=0.
  - If mem_req=1, accept MEM: latch addr, write, data and count N.
  - Else if if_req=1, accept IF: N=4, read.
  - MEM has fixed priority on simultaneous requests. IF waits; no starvation guard is needed because MEM requests are pipeline-bounded.
  - Next state XFER with idx=0.
- N is decoded from mem_byte: 0001→1, 0011→2, 1111→4. Any other mask is treated as 1111.
- XFER, one cycle per byte idx = 0..N-1:
  - ram_a = (addr + idx)[ADDR_W-1:0]. Address wrap-around is modulo 2^ADDR_W; unaligned addresses are legal.
  - Writes: ram_wr=1, ram_din = wdata byte idx.
  - Reads: ram_wr=0. The byte for idx-1 is captured from ram_dout into result byte idx-1 (when idx>0).
  - After idx = N-1: writes go to DONE, reads go to LAST.
- LAST (reads only): ram_wr=0; capture byte N-1 from ram_dout; next state DONE.
- DONE: pulse the owner's done for exactly one cycle. if_data or mem_rdata shows the assembled word with bytes ≥N zero. Next state IDLE unconditionally.
- Latency, with the accept cycle as cycle 0:
  - Read of N bytes: done in cycle N+2 (IF fetch: cycle 6).
  - Write of N bytes: done in cycle N+1 (sw: cycle 5).
- Back-to-back: a request held high in the IDLE cycle after DONE is accepted as a new transaction. Minimum one idle cycle between transactions.
- Inputs changing mid-transaction are ignored because all request fields are latched.
- Output data registers of the non-owner are untouched by a transaction.

Test Plan:
- IF fetch: RAM[0x100..0x103] = 13,05,00,00; if_req, if_addr=0x100 → if_done in cycle 6 with if_data=0x00000513; ram_a sequence 0x100–0x103; ram_wr never high.
- MEM lb: mem_byte=0001, addr=0x20, RAM[0x20]=0xF3 → mem_done in cycle 3 with mem_rdata=0x000000F3 (zero-filled).
- MEM sh write: mem_write=1, mem_byte=0011, addr=0x104, wdata=0xAABB1234 → ram_wr high exactly 2 cycles, (0x104,0x34) then (0x105,0x12); mem_done in cycle 3; RAM[0x106] unchanged.
- Simultaneous: if_req and mem_req (lw 0x200) rise together → MEM served first (mem_done cycle 6). IF is accepted in the IDLE cycle after that and gets if_done 6 cycles later. Exactly one done pulse is high at a time.
- Reset mid-op: assert rst during XFER idx=1 of a sw → ram_wr, busy and done fall immediately; state IDLE; after release, a new lw completes normally with correct data.
- Wrap: lw at addr 0x1FFFF with ADDR_W=17 → ram_a sequence 0x1FFFF, 0x00000, 0x00001, 0x00002; bytes assembled in that order.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates IF and MEM onto a byte-wide synchronous RAM, serialising word/half/byte transfers.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout
);
  localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, LAST = 2'd2, DONE = 2'd3;
  logic [1:0] state, idx, nm1, idx_m1, n_dec;
  logic own_mem, wr;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata, rbuf, last_word;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};
  assign n_dec = mem_byte == 4'b0001 ? 2'd0 : mem_byte == 4'b0011 ? 2'd1 : 2'd3;
  assign idx_m1 = idx - 2'd1;
  // rbuf is cleared on accept, so bytes beyond N stay zero in the merged word
  assign last_word = rbuf | ({24'd0, ram_dout} << {nm1, 3'b000});
  assign busy = state != IDLE;
  assign ram_wr = state == XFER && wr;
  assign ram_a = state == XFER ? addr + ADDR_W'(idx) : '0;
  assign ram_din = ram_wr ? wdata[{idx, 3'b000} +: 8] : 8'd0;
  assign if_done = state == DONE && !own_mem;
  assign mem_done = state == DONE && own_mem;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      nm1 <= '0;
      own_mem <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rbuf <= '0;
      if_data <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (mem_req || if_req) begin
          state <= XFER;
          idx <= 2'd0;
          rbuf <= '0;
          own_mem <= mem_req;
          wr <= mem_req && mem_write;
          addr <= mem_req ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
          wdata <= mem_wdata;
          nm1 <= mem_req ? n_dec : 2'd3;
        end
        XFER: begin
          idx <= idx + 2'd1;
          if (!wr && idx != 2'd0) rbuf[{idx_m1, 3'b000} +: 8] <= ram_dout;
          if (idx == nm1) state <= wr ? DONE : LAST;
        end
        LAST: begin
          state <= DONE;
          if (own_mem) mem_rdata <= last_word;
          else if_data <= last_word;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenario tests for mem_ctrl against a byte-wide synchronous RAM model.
module tb_mem_ctrl;
  logic clk = 0, rst = 1;
  logic if_req = 0, if_done, mem_req = 0, mem_write = 0, mem_done, busy, ram_wr;
  logic [31:0] if_addr = 0, if_data, mem_addr = 0, mem_wdata = 0, mem_rdata;
  logic [3:0] mem_byte = 4'b1111;
  logic [16:0] ram_a;
  logic [7:0] ram_din, ram_dout = 0;
  logic [7:0] ram [0:131071];
  logic [16:0] a_log [0:19];
  logic w_log [0:19];
  logic [7:0] d_log [0:19];
  logic [31:0] if_got, mem_got;
  int if_cyc, mem_cyc, both_hi, errors = 0, checks = 0;

  mem_ctrl #(.ADDR_W(17)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_write(mem_write), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a] <= ram_din;
    ram_dout <= ram[ram_a];
  end

  // Caller raises requests just after a rising edge; that cycle is cycle 0.
  task automatic run();
    if_cyc = -1;
    mem_cyc = -1;
    both_hi = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a_log[c] = ram_a;
      w_log[c] = ram_wr;
      d_log[c] = ram_din;
      if (if_done && mem_done) both_hi++;
      if (if_done) begin if_cyc = c; if_got = if_data; if_req = 0; end
      if (mem_done) begin mem_cyc = c; mem_got = mem_rdata; mem_req = 0; end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({ram_wr, ram_a, ram_din} !== 26'd0) begin errors++; $display("FAIL reset_ram got wr=%b a=%h din=%h exp 0", ram_wr, ram_a, ram_din); end
    checks++; if ({if_done, mem_done} !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", {if_done, mem_done}); end
    checks++; if ({if_data, mem_rdata} !== 64'd0) begin errors++; $display("FAIL reset_data got %h %h exp 0", if_data, mem_rdata); end
    rst = 0;
  endtask

  task automatic test_if_fetch();
    ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'h00; ram[17'h103] = 8'h00;
    @(posedge clk); #1;
    if_addr = 32'h100; if_req = 1;
    run();
    checks++; if (if_cyc !== 6) begin errors++; $display("FAIL if_latency got %0d exp 6", if_cyc); end
    checks++; if (if_got !== 32'h00000513) begin errors++; $display("FAIL if_data got %h exp 00000513", if_got); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_log[i+1] !== 17'h100 + 17'(i)) begin errors++; $display("FAIL if_addr%0d got %h exp %h", i, a_log[i+1], 17'h100 + 17'(i)); end
    end
    for (int i = 0; i < 20; i++) begin
      checks++; if (w_log[i] !== 1'b0) begin errors++; $display("FAIL if_nowrite cycle %0d got 1 exp 0", i); end
    end
  endtask

  task automatic test_lb();
    ram[17'h20] = 8'hF3;
    @(posedge clk); #1;
    mem_write = 0; mem_byte = 4'b0001; mem_addr = 32'h20; mem_req = 1;
    run();
    checks++; if (mem_cyc !== 3) begin errors++; $display("FAIL lb_latency got %0d exp 3", mem_cyc); end
    checks++; if (mem_got !== 32'h000000F3) begin errors++; $display("FAIL lb_data got %h exp 000000f3", mem_got); end
    checks++; if (if_data !== 32'h00000513) begin errors++; $display("FAIL lb_if_untouched got %h exp 00000513", if_data); end
  endtask

  task automatic test_sh();
    int nw;
    ram[17'h106] = 8'h77;
    @(posedge clk); #1;
    mem_write = 1; mem_byte = 4'b0011; mem_addr = 32'h104; mem_wdata = 32'hAABB1234; mem_req = 1;
    run();
    mem_write = 0;
    nw = 0;
    for (int i = 0; i < 20; i++) nw += int'(w_log[i]);
    checks++; if (nw !== 2) begin errors++; $display("FAIL sh_wr_cycles got %0d exp 2", nw); end
    checks++; if ({w_log[1], a_log[1], d_log[1]} !== {1'b1, 17'h104, 8'h34}) begin errors++; $display("FAIL sh_byte0 got wr=%b a=%h d=%h exp 1 104 34", w_log[1], a_log[1], d_log[1]); end
    checks++; if ({w_log[2], a_log[2], d_log[2]} !== {1'b1, 17'h105, 8'h12}) begin errors++; $display("FAIL sh_byte1 got wr=%b a=%h d=%h exp 1 105 12", w_log[2], a_log[2], d_log[2]); end
    checks++; if (mem_cyc !== 3) begin errors++; $display("FAIL sh_latency got %0d exp 3", mem_cyc); end
    checks++; if ({ram[17'h104], ram[17'h105], ram[17'h106]} !== 24'h341277) begin errors++; $display("FAIL sh_ram got %h %h %h exp 34 12 77", ram[17'h104], ram[17'h105], ram[17'h106]); end
  endtask

  task automatic test_simultaneous();
    ram[17'h200] = 8'h11; ram[17'h201] = 8'h22; ram[17'h202] = 8'h33; ram[17'h203] = 8'h44;
    ram[17'h300] = 8'hDE; ram[17'h301] = 8'hAD; ram[17'h302] = 8'hBE; ram[17'h303] = 8'hEF;
    @(posedge clk); #1;
    mem_byte = 4'b1111; mem_addr = 32'h200; if_addr = 32'h300; mem_req = 1; if_req = 1;
    run();
    checks++; if (mem_cyc !== 6) begin errors++; $display("FAIL sim_mem_latency got %0d exp 6", mem_cyc); end
    checks++; if (mem_got !== 32'h44332211) begin errors++; $display("FAIL sim_mem_data got %h exp 44332211", mem_got); end
    checks++; if (if_cyc !== 13) begin errors++; $display("FAIL sim_if_latency got %0d exp 13", if_cyc); end
    checks++; if (if_got !== 32'hEFBEADDE) begin errors++; $display("FAIL sim_if_data got %h exp efbeadde", if_got); end
    checks++; if (both_hi !== 0) begin errors++; $display("FAIL sim_one_done got %0d overlaps exp 0", both_hi); end
  endtask

  task automatic test_bad_mask();
    @(posedge clk); #1;
    mem_byte = 4'b0110; mem_addr = 32'h200; mem_req = 1;
    run();
    checks++; if (mem_cyc !== 6) begin errors++; $display("FAIL mask_latency got %0d exp 6", mem_cyc); end
    checks++; if (mem_got !== 32'h44332211) begin errors++; $display("FAIL mask_data got %h exp 44332211", mem_got); end
  endtask

  task automatic test_reset_mid();
    ram[17'h40] = 8'h01; ram[17'h41] = 8'h02; ram[17'h42] = 8'h03; ram[17'h43] = 8'h04;
    @(posedge clk); #1;
    mem_write = 1; mem_byte = 4'b1111; mem_addr = 32'h40; mem_wdata = 32'h89ABCDEF; mem_req = 1;
    repeat (3) @(negedge clk);
    checks++; if ({ram_wr, ram_a} !== {1'b1, 17'h41}) begin errors++; $display("FAIL mid_pre got wr=%b a=%h exp 1 41", ram_wr, ram_a); end
    rst = 1; mem_req = 0; mem_write = 0;
    #1;
    checks++; if ({ram_wr, busy, mem_done} !== 3'b000) begin errors++; $display("FAIL mid_abort got wr/busy/done=%b exp 000", {ram_wr, busy, mem_done}); end
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    mem_addr = 32'h40; mem_req = 1;
    run();
    checks++; if (mem_cyc !== 6) begin errors++; $display("FAIL mid_lw_latency got %0d exp 6", mem_cyc); end
    checks++; if (mem_got !== 32'h040302EF) begin errors++; $display("FAIL mid_lw_data got %h exp 040302ef", mem_got); end
  endtask

  task automatic test_wrap();
    ram[17'h1FFFF] = 8'hA1; ram[17'h0] = 8'hB2; ram[17'h1] = 8'hC3; ram[17'h2] = 8'hD4;
    @(posedge clk); #1;
    mem_byte = 4'b1111; mem_addr = 32'h0001FFFF; mem_req = 1;
    run();
    checks++; if ({a_log[1], a_log[2], a_log[3], a_log[4]} !== {17'h1FFFF, 17'h0, 17'h1, 17'h2}) begin errors++; $display("FAIL wrap_addr got %h %h %h %h exp 1ffff 0 1 2", a_log[1], a_log[2], a_log[3], a_log[4]); end
    checks++; if (mem_got !== 32'hD4C3B2A1) begin errors++; $display("FAIL wrap_data got %h exp d4c3b2a1", mem_got); end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_lb();
    test_sh();
    test_simultaneous();
    test_bad_mask();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
